// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: armed serial pattern detector with match counting, hit target and bit-window timeout
module seq_detect_ctrl #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] window,
    input  logic             x,
    input  logic             x_valid,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             hit,
    output logic             timeout
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pat, hist, hist_n;
    logic             ovl;
    logic [CNT_W-1:0] tgt, win, bit_cnt, bit_n, cnt_n;
    logic [FW-1:0]    fill, fill_n;
    logic             is_match, hit_n, to_n;

    // next-bit view of the detector, used only when a bit is accepted in RUN
    always_comb begin
        hist_n   = {hist[PAT_W-2:0], x};
        fill_n   = (fill == FULL) ? FULL : fill + 1'b1;
        is_match = (hist_n == pat) && (fill_n == FULL);
        cnt_n    = match_count + {{(CNT_W-1){1'b0}}, is_match && !(&match_count)};
        bit_n    = bit_cnt + 1'b1;
        hit_n    = (tgt != '0) && is_match && (cnt_n == tgt);
        to_n     = (win != '0) && (bit_n == win) && !hit_n;
    end

    // session FSM with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pat         <= '0;
            ovl         <= 1'b0;
            tgt         <= '0;
            win         <= '0;
            hist        <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            busy        <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            done        <= 1'b0;
            hit         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            match <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state       <= RUN;
                    pat         <= pattern;
                    ovl         <= overlap;
                    tgt         <= target;
                    win         <= window;
                    hist        <= '0;
                    fill        <= '0;
                    bit_cnt     <= '0;
                    match_count <= '0;
                    hit         <= 1'b0;
                    timeout     <= 1'b0;
                    busy        <= 1'b1;
                end
                RUN: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (x_valid) begin
                    hist        <= hist_n;
                    fill        <= (is_match && !ovl) ? '0 : fill_n;
                    bit_cnt     <= bit_n;
                    match       <= is_match;
                    match_count <= cnt_n;
                    hit         <= hit_n;
                    timeout     <= to_n;
                    done        <= hit_n || to_n;
                    state       <= (hit_n || to_n) ? DONE : RUN;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed and randomized checks against a bit-queue session model
module tb_seq_detect_ctrl;
    localparam int PAT_W = 3;
    localparam int CNT_W = 8;

    logic             clk, rst, start, abort, overlap, x, x_valid;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] target, window;
    logic             busy, match, done, hit, timeout;
    logic [CNT_W-1:0] match_count;

    int n_tests = 0;
    int n_fail  = 0;

    seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
        .overlap(overlap), .target(target), .window(window), .x(x), .x_valid(x_valid),
        .busy(busy), .match(match), .match_count(match_count), .done(done),
        .hit(hit), .timeout(timeout)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // reference model: session phase plus the list of bits accepted since the last restart
    int m_phase;
    int q[$];
    int m_pat, m_ovl, m_tgt, m_win, m_bits, m_cnt;
    int m_busy, m_match, m_done, m_hit, m_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; q.delete();
        m_bits = 0; m_cnt = 0;
        m_busy = 0; m_match = 0; m_done = 0; m_hit = 0; m_to = 0;
    endtask

    task automatic model_edge();
        int v;
        m_match = 0; m_done = 0;
        if (m_phase == 0) begin
            if (start) begin
                m_pat = int'(pattern); m_ovl = int'(overlap);
                m_tgt = int'(target);  m_win = int'(window);
                q.delete(); m_bits = 0; m_cnt = 0; m_hit = 0; m_to = 0;
                m_phase = 1; m_busy = 1;
            end
        end else if (m_phase == 1) begin
            if (abort) begin
                m_phase = 0; m_busy = 0;
            end else if (x_valid) begin
                q.push_back(int'(x));
                m_bits++;
                if (q.size() >= PAT_W) begin
                    v = 0;
                    for (int i = q.size() - PAT_W; i < q.size(); i++) v = v * 2 + q[i];
                    if (v == m_pat) begin
                        m_match = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (m_ovl == 0) q.delete();
                    end
                end
                if (m_tgt != 0 && m_match == 1 && m_cnt == m_tgt) m_hit = 1;
                else if (m_win != 0 && (m_bits % 256) == m_win) m_to = 1;
                if (m_hit == 1 || m_to == 1) begin
                    m_phase = 2; m_done = 1;
                end
            end
        end else begin
            m_phase = 0; m_busy = 0;
        end
    endtask

    task automatic check_all();
        chk("busy", busy, m_busy);
        chk("match", match, m_match);
        chk("match_count", match_count, m_cnt);
        chk("done", done, m_done);
        chk("hit", hit, m_hit);
        chk("timeout", timeout, m_to);
    endtask

    task automatic cyc(input logic st, input logic ab, input logic xb, input logic xv);
        start = st; abort = ab; x = xb; x_valid = xv;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        start = 0; abort = 0; x_valid = 0;
        pattern = PAT_W'($urandom); overlap = 1'($urandom);
        target = CNT_W'($urandom); window = CNT_W'($urandom);
    endtask

    task automatic arm(input int p, input int o, input int t, input int w);
        pattern = PAT_W'(p); overlap = 1'(o); target = CNT_W'(t); window = CNT_W'(w);
        cyc(1, 0, 0, 0);
    endtask

    task automatic feed(input int bits[$]);
        foreach (bits[i]) cyc(0, 0, 1'(bits[i]), 1);
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; x = 0; x_valid = 0;
        pattern = '0; overlap = 0; target = '0; window = '0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 0;

        // non-overlapping 101 on 10101: one match
        arm(3'b101, 0, 0, 0);
        feed('{1, 0, 1, 0, 1});
        chk("nonovl_count", match_count, 1);
        cyc(0, 1, 0, 0);

        // overlapping 101 on 10101: two matches
        arm(3'b101, 1, 0, 0);
        feed('{1, 0, 1, 0, 1});
        chk("ovl_count", match_count, 2);
        cyc(0, 1, 0, 0);

        // hit on second 110; trailing bit lands in DONE and is ignored
        arm(3'b110, 0, 2, 0);
        feed('{1, 1, 0, 1, 1, 0});
        chk("hit_done", done, 1);
        chk("hit_level", hit, 1);
        cyc(0, 0, 1, 1);
        chk("hit_busy_low", busy, 0);
        chk("hit_count_kept", match_count, 2);

        // timeout, then same-bit hit priority
        arm(3'b111, 0, 1, 4);
        feed('{0, 0, 0, 0});
        chk("to_level", timeout, 1);
        cyc(0, 0, 0, 0);
        arm(3'b111, 0, 1, 4);
        feed('{0, 1, 1, 1});
        chk("prio_hit", hit, 1);
        chk("prio_to", timeout, 0);
        cyc(0, 0, 0, 0);

        // abort together with a valid bit, then restart with fresh history
        arm(3'b101, 1, 0, 0);
        feed('{1, 0});
        cyc(0, 1, 1, 1);
        chk("abort_busy", busy, 0);
        cyc(0, 0, 0, 0);
        arm(3'b101, 1, 0, 0);
        feed('{1});
        chk("stale_match", match, 0);

        // x_valid gaps inside the pattern
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        feed('{0});
        cyc(0, 0, 0, 0);
        feed('{1});
        chk("gap_match", match, 1);

        // asynchronous reset mid-session
        #3 rst = 1;
        #1 model_reset();
        check_all();
        #1 rst = 0;
        arm(3'b011, 0, 0, 0);
        chk("post_rst_busy", busy, 1);
        cyc(0, 1, 0, 0);

        // randomized traffic with random config every cycle
        for (int n = 0; n < 3000; n++) begin
            pattern = PAT_W'($urandom); overlap = 1'($urandom);
            target  = CNT_W'($urandom_range(0, 4));
            window  = ($urandom_range(0, 3) == 0) ? '0 : CNT_W'($urandom_range(1, 24));
            cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0),
                1'($urandom), 1'($urandom_range(0, 9) < 7));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Session controller for serial bit-pattern detection. It is armed with a programmable pattern, an overlap mode, a match target and a bit-window limit. It then consumes a qualified serial bit stream, counts pattern matches, and ends the session with a one-cycle done pulse and a hit or timeout status. It sits between the register/control logic and the raw serial input, replacing hard-wired single-pattern Moore detectors such as fixed 101 detectors.

## Interface
- PAT_W, 3, pattern length in bits (2..8)
- CNT_W, 8, width of the target, window and match counters
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  arm request; sampled only in IDLE
- abort  input  1  cancel request; sampled only in RUN
- pattern  input  PAT_W  pattern to detect; MSB is the oldest bit; latched on start
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping; latched on start
- target  input  CNT_W  matches needed for hit; 0 = unlimited; latched on start
- window  input  CNT_W  maximum accepted bits before timeout; 0 = no limit; latched on start
- x  input  1  serial data bit
- x_valid  input  1  x is sampled only when high, and only in RUN
- busy  output  1  high in RUN and DONE
- match  output  1  one-cycle pulse per detected pattern
- match_count  output  CNT_W  matches in the current or last session; saturates at all-ones
- done  output  1  one-cycle pulse; session ended by hit or timeout
- hit  output  1  level; target reached; held until next start
- timeout  output  1  level; window exhausted before target; held until next start

## Operation
- States:
  - IDLE: start → RUN. The start edge latches the config and clears history, fill, bit_cnt, match_count, hit and timeout.
  - RUN: stays until hit, timeout or abort.
  - DONE: lasts exactly 1 cycle, then → IDLE.
- Shift history: hist_n = {hist[PAT_W-2:0], x}. The fill counter (0..PAT_W, saturating) counts valid bits since the last restart.
- Match condition on an accepted bit: hist_n == pattern_latched and fill_n == PAT_W.
- Non-overlap mode: on a match, fill resets to 0, so the next match needs PAT_W fresh bits.
- Overlap mode: fill stays at PAT_W, so suffix bits are reused.
- bit_cnt increments on every accepted bit. match_count increments on every match, saturating.
- Hit: target != 0 and the new match_count == target → DONE, hit=1.
- Timeout: window != 0 and the new bit_cnt == window, without a hit on that bit → DONE, timeout=1.
- Hit and timeout on the same bit: hit wins; timeout stays 0.
- target == 0 and window == 0: the session runs until abort.
- Abort in RUN → IDLE next edge:
  - no done pulse;
  - hit and timeout stay 0;
  - match_count is retained;
  - an x_valid bit in the same cycle is discarded.
- Ignored inputs:
  - start in RUN or DONE;
  - abort in IDLE or DONE;
  - x_valid outside RUN.
- Config inputs are don't-care except in the start cycle.

## Timing
- Reset (asynchronous, any state, including mid-session):
  - state IDLE;
  - busy, match, done, hit and timeout = 0;
  - match_count = 0;
  - history, fill and bit_cnt = 0.
- All outputs are registered; there are no combinational input→output paths.
- Start sampled at edge N: busy=1 from N; the first bit can be accepted at edge N+1.
- The edge that samples the completing bit sets match=1, match_count+1, and hit/timeout if applicable. Result latency is 1 cycle: visible in the following cycle.
- done=1 for exactly the cycle in which the state is DONE. busy falls on the next edge.
- A new start is accepted the cycle after DONE, i.e. at the earliest 2 cycles after the final bit.
- Back-to-back x_valid on every cycle is supported at full rate.

## Test plan
- Non-overlap: PAT_W=3, pattern=101, overlap=0, target=0, window=0; stream 1,0,1,0,1 → match pulses once, after the 3rd bit only; match_count=1.
- Overlap: the same stream with overlap=1 → match after bits 3 and 5; match_count=2.
- Hit: pattern=110, target=2, overlap=0; stream 1,1,0,1,1,0,1 → done one cycle after bit 6; hit=1, timeout=0; bit 7 ignored; busy low afterwards.
- Timeout and priority:
  - window=4, target=1, pattern=111; stream 0,0,0,0 → timeout=1 and hit=0 after bit 4.
  - Rerun with 0,1,1,1 → hit=1 and timeout=0 (same-bit priority).
- Abort: start, feed 1,0, assert abort together with x_valid → IDLE; no done; hit=timeout=0; the bit is discarded.
  - Then start again: the stale history from the aborted session does not produce a match on 1.
- Reset mid-session: assert rst asynchronously between clock edges while in RUN → all outputs 0 immediately; start is accepted after rst deasserts.
- x_valid gaps: insert idle cycles inside the pattern → detection is unaffected.
